// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter with a registered grant, a 4:1 data mux
// and a per-tenure burst limit of MAX_BURST beats.
module rr_mux_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       out_id,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             dbg_state,
  output logic [1:0]       dbg_ptr,
  output logic [3:0]       dbg_bcnt
);

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  logic       state;
  logic [1:0] ptr;
  logic [3:0] bcnt;

  logic       beat;
  logic       release_now;
  logic [1:0] arb_base;
  logic [1:0] winner;
  logic       any_req;

  // First set request scanning base+1, base+2, base+3, base; base itself is lowest.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = base;
    found = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      idx = base + 2'(d);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Handshake: a beat moves when out_valid and out_ready are both high on a
  // rising edge; out_valid never depends on out_ready, and a stalled owner
  // keeps its grant for as long as it keeps requesting.
  always_comb begin
    out_valid   = (state == GRANT) && req[out_id];
    beat        = out_valid && out_ready;
    release_now = (state == GRANT) && (!req[out_id] || (beat && (bcnt == LAST_BEAT)));
    arb_base    = (state == GRANT) ? out_id : ptr;
    winner      = pick(req, arb_base);
    any_req     = |req;
  end

  always_comb begin
    out_data = in0;
    case (out_id)
      2'd0: out_data = in0;
      2'd1: out_data = in1;
      2'd2: out_data = in2;
      2'd3: out_data = in3;
      default: out_data = in0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= 4'b0000;
      out_id <= 2'd0;
      ptr    <= 2'd3;
      bcnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state  <= GRANT;
            out_id <= winner;
            gnt    <= 4'b0001 << winner;
            bcnt   <= 4'd0;
          end else begin
            gnt <= 4'b0000;
          end
        end
        GRANT: begin
          if (release_now) begin
            // Re-arbitrate in the same cycle so there is no idle bubble.
            ptr  <= out_id;
            bcnt <= 4'd0;
            if (any_req) begin
              out_id <= winner;
              gnt    <= 4'b0001 << winner;
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
            end
          end else if (beat) begin
            bcnt <= bcnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          bcnt  <= 4'd0;
        end
      endcase
    end
  end

  assign dbg_state = state;
  assign dbg_ptr   = ptr;
  assign dbg_bcnt  = bcnt;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: two instances (burst 4 and burst 1) on shared
// inputs, checked every cycle against a tenure-level reference model.
module tb_rr_mux_arbiter;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [W-1:0] in0, in1, in2, in3;
  logic         out_ready;

  logic [3:0]   gnt_o   [2];
  logic [1:0]   id_o    [2];
  logic         valid_o [2];
  logic [W-1:0] data_o  [2];
  logic         state_o [2];
  logic [1:0]   ptr_o   [2];
  logic [3:0]   bcnt_o  [2];

  int total = 0;
  int bad   = 0;

  bit m_busy  [2];
  int m_id    [2];
  int m_last  [2];
  int m_beats [2];
  int m_limit [2] = '{4, 1};

  logic [1:0] exp_q[$];

  rr_mux_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut_a (
    .clk(clk), .reset(reset), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .out_ready(out_ready),
    .gnt(gnt_o[0]), .out_id(id_o[0]), .out_valid(valid_o[0]), .out_data(data_o[0]),
    .dbg_state(state_o[0]), .dbg_ptr(ptr_o[0]), .dbg_bcnt(bcnt_o[0])
  );

  rr_mux_arbiter #(.WIDTH(W), .MAX_BURST(1)) dut_b (
    .clk(clk), .reset(reset), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .out_ready(out_ready),
    .gnt(gnt_o[1]), .out_id(id_o[1]), .out_valid(valid_o[1]), .out_data(data_o[1]),
    .dbg_state(state_o[1]), .dbg_ptr(ptr_o[1]), .dbg_bcnt(bcnt_o[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] sel_in(input int i);
    case (i)
      0: return in0;
      1: return in1;
      2: return in2;
      default: return in3;
    endcase
  endfunction

  // Round robin: first requester after 'last' going upward mod 4, 'last' itself last.
  function automatic int next_owner(input logic [3:0] r, input int last);
    for (int d = 1; d <= 4; d++) begin
      if (r[(last + d) % 4]) return (last + d) % 4;
    end
    return last;
  endfunction

  task automatic model_reset(input int k);
    m_busy[k]  = 1'b0;
    m_id[k]    = 0;
    m_last[k]  = 3;
    m_beats[k] = 0;
  endtask

  // Advances the model across one rising edge using the inputs held before it.
  task automatic model_tick(input int k);
    bit moved;
    int done;
    if (reset) begin
      model_reset(k);
      return;
    end
    if (!m_busy[k]) begin
      if (req != 4'b0000) begin
        m_busy[k]  = 1'b1;
        m_id[k]    = next_owner(req, m_last[k]);
        m_beats[k] = 0;
      end
      return;
    end
    moved = req[m_id[k]] && out_ready;
    done  = m_beats[k] + (moved ? 1 : 0);
    if (!req[m_id[k]] || done == m_limit[k]) begin
      m_last[k]  = m_id[k];
      m_beats[k] = 0;
      if (req != 4'b0000) m_id[k] = next_owner(req, m_last[k]);
      else m_busy[k] = 1'b0;
    end else begin
      m_beats[k] = done;
    end
  endtask

  // driver: inputs are already applied; compare this cycle, then cross one edge
  task automatic step();
    logic [3:0] eg;
    logic       ev;
    #1;
    for (int k = 0; k < 2; k++) begin
      eg = m_busy[k] ? 4'(4'b0001 << m_id[k]) : 4'b0000;
      ev = m_busy[k] && req[m_id[k]];
      total++;
      if (gnt_o[k] !== eg) begin
        bad++; $display("FAIL gnt[%0d] t=%0t got=%b exp=%b", k, $time, gnt_o[k], eg);
      end
      total++;
      if (id_o[k] !== 2'(m_id[k])) begin
        bad++; $display("FAIL out_id[%0d] t=%0t got=%0d exp=%0d", k, $time, id_o[k], m_id[k]);
      end
      total++;
      if (valid_o[k] !== ev) begin
        bad++; $display("FAIL out_valid[%0d] t=%0t got=%b exp=%b", k, $time, valid_o[k], ev);
      end
      total++;
      if (bcnt_o[k] !== 4'(m_beats[k])) begin
        bad++; $display("FAIL bcnt[%0d] t=%0t got=%0d exp=%0d", k, $time, bcnt_o[k], m_beats[k]);
      end
      total++;
      if (ptr_o[k] !== 2'(m_last[k])) begin
        bad++; $display("FAIL ptr[%0d] t=%0t got=%0d exp=%0d", k, $time, ptr_o[k], m_last[k]);
      end
      total++;
      if (state_o[k] !== m_busy[k]) begin
        bad++; $display("FAIL state[%0d] t=%0t got=%b exp=%b", k, $time, state_o[k], m_busy[k]);
      end
      if (ev) begin
        total++;
        if (data_o[k] !== sel_in(m_id[k])) begin
          bad++; $display("FAIL out_data[%0d] t=%0t got=%h exp=%h", k, $time, data_o[k], sel_in(m_id[k]));
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_tick(k);
    #1;
  endtask

  task automatic rand_data();
    in0 = W'($urandom);
    in1 = W'($urandom);
    in2 = W'($urandom);
    in3 = W'($urandom);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = 4'b0000;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_reset(k);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req       = 4'($urandom_range(0, 15));
    out_ready = 1'b1;
    rand_data();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_reset(k);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (gnt_o[k] !== 4'b0000 || id_o[k] !== 2'd0 || valid_o[k] !== 1'b0 ||
          ptr_o[k] !== 2'd3 || bcnt_o[k] !== 4'd0 || state_o[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state[%0d] got gnt=%b id=%0d v=%b ptr=%0d bcnt=%0d st=%b exp 0000/0/0/3/0/0",
                 k, gnt_o[k], id_o[k], valid_o[k], ptr_o[k], bcnt_o[k], state_o[k]);
      end
    end
    step();
    reset = 1'b0;
    req   = 4'b0000;
    step();
  endtask

  task automatic test_rr_full();
    apply_reset();
    req       = 4'b1111;
    out_ready = 1'b1;
    rand_data();
    step();
    exp_q.delete();
    foreach (exp_q[i]) exp_q.delete(i);
    for (int t = 0; t < 5; t++) begin
      for (int b = 0; b < 4; b++) exp_q.push_back(2'(t % 4));
    end
    while (exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      total++;
      if (id_o[0] !== e || gnt_o[0] !== 4'(4'b0001 << e)) begin
        bad++; $display("FAIL rr_order got id=%0d gnt=%b exp id=%0d", id_o[0], gnt_o[0], e);
      end
      rand_data();
      step();
    end
  endtask

  task automatic test_sole();
    apply_reset();
    req       = 4'b0100;
    out_ready = 1'b1;
    in2       = '0;
    step();
    for (int i = 0; i < 13; i++) begin
      in2 = in2 + 1'b1;
      total++;
      if (gnt_o[0] !== 4'b0100) begin
        bad++; $display("FAIL sole_gnt cyc=%0d got=%b exp=0100", i, gnt_o[0]);
      end
      step();
    end
  endtask

  task automatic test_stall();
    apply_reset();
    req       = 4'b0010;
    out_ready = 1'b1;
    rand_data();
    step();
    step();
    step();
    out_ready = 1'b0;
    req       = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (gnt_o[0] !== 4'b0010 || bcnt_o[0] !== 4'd2) begin
        bad++; $display("FAIL stall_hold cyc=%0d got gnt=%b bcnt=%0d exp 0010/2", i, gnt_o[0], bcnt_o[0]);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    step();
    total++;
    if (gnt_o[0] !== 4'b1000) begin
      bad++; $display("FAIL stall_next got=%b exp=1000", gnt_o[0]);
    end
    step();
  endtask

  task automatic test_drop();
    apply_reset();
    req       = 4'b0101;
    out_ready = 1'b1;
    rand_data();
    step();
    step();
    req = 4'b0100;
    step();
    total++;
    if (gnt_o[0] !== 4'b0100 || id_o[0] !== 2'd2 || ptr_o[0] !== 2'd0) begin
      bad++; $display("FAIL drop_regrant got gnt=%b id=%0d ptr=%0d exp 0100/2/0", gnt_o[0], id_o[0], ptr_o[0]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req       = 4'b1000;
    out_ready = 1'b1;
    rand_data();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (gnt_o[0] !== 4'b0000 || valid_o[0] !== 1'b0 || id_o[0] !== 2'd0) begin
      bad++; $display("FAIL reset_mid got gnt=%b v=%b id=%0d exp 0000/0/0", gnt_o[0], valid_o[0], id_o[0]);
    end
    req = 4'b1001;
    step();
    total++;
    if (gnt_o[0] !== 4'b0001 || id_o[0] !== 2'd0) begin
      bad++; $display("FAIL reset_prio got gnt=%b id=%0d exp 0001/0", gnt_o[0], id_o[0]);
    end
    step();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req       = 4'b0101;
    out_ready = 1'b1;
    rand_data();
    step();
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 2'd0 : 2'd2);
    while (exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      total++;
      if (id_o[1] !== e || gnt_o[1] !== 4'(4'b0001 << e) || valid_o[1] !== 1'b1) begin
        bad++; $display("FAIL burst1_alt got id=%0d gnt=%b v=%b exp id=%0d", id_o[1], gnt_o[1], valid_o[1], e);
      end
      rand_data();
      step();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      req       = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    test_reset();
    test_rr_full();
    test_sole();
    test_stall();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data width of each requester port and the output.
REQ-002 Parameter MAX_BURST, default 4, legal range 1..16: maximum transfers per grant tenure.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  req[i] asserted: requester i has data on in_i.
REQ-006 in0, in1, in2, in3  input  WIDTH each  requester data.
REQ-007 out_ready  input  1  downstream accepts the current beat.
REQ-008 gnt  output  4  registered one-hot grant; all zero when idle.
REQ-009 out_id  output  2  registered index of the current owner; also the 4:1 select.
REQ-010 out_valid  output  1  equals req[out_id] while in GRANT, else 0 (combinational).
REQ-011 out_data  output  WIDTH  in_{out_id}, combinational 4:1 select; value is don't-care when out_valid=0.

Function
REQ-012 The FSM SHALL have two states: IDLE and GRANT.
REQ-013 Transfer (beat) SHALL occur on any cycle with out_valid=1 and out_ready=1.
REQ-014 Pointer ptr[1:0] SHALL hold the last owner; priority order SHALL be ptr+1, ptr+2, ptr+3, ptr, all mod 4.
REQ-015 IDLE, any req set: the next state SHALL be GRANT; the owner SHALL be the first set req in priority order; gnt/out_id SHALL update at the next edge (1-cycle req-to-grant latency).
REQ-016 IDLE, req=0: the block SHALL stay in IDLE with gnt=0 and out_id held.
REQ-017 Beat counter bcnt (4 bits) SHALL clear on every new grant and increment on each beat.
REQ-018 Release SHALL occur in GRANT when (a) a beat occurs with bcnt==MAX_BURST-1, or (b) req[out_id]=0 in that cycle.
REQ-019 On release, ptr SHALL load out_id, and re-arbitration SHALL use the same-cycle req vector with the updated order (released owner lowest), with no idle bubble: if any req is set, the next owner is granted at the next edge; otherwise the state goes to IDLE.
REQ-020 A sole requester SHALL be re-granted after release (new tenure, bcnt=0).
REQ-021 Without release, GRANT SHALL hold owner, gnt and ptr unchanged, including while out_ready=0 (no preemption while stalled).
REQ-022 Requesters other than the owner SHALL be ignored during a tenure; their req does not need to be held stable.
REQ-023 gnt SHALL always be one-hot or zero; gnt[out_id]=1 exactly when in GRANT.
REQ-024 MAX_BURST=1: every beat SHALL cause a release, giving strict per-beat round robin.
REQ-025 bcnt SHALL NOT wrap within a tenure; release at MAX_BURST-1 precedes overflow.

Reset
REQ-026 With reset=1 at an edge: state=IDLE, gnt=0, out_id=0, ptr=3, bcnt=0; out_valid SHALL be 0 in the following cycle.
REQ-027 Reset SHALL take priority over all other inputs; reset mid-tenure SHALL abort it with no further beats credited.
REQ-028 After reset, requester 0 SHALL have highest priority.

Verification
REQ-029 Reset, then req=4'b1111, out_ready=1 -> grants 0,1,2,3,0 in order; each tenure exactly 4 beats; no idle cycle between tenures.
REQ-030 MAX_BURST=4, req=4'b0100 only, in2 incrementing, out_ready=1 -> gnt=4'b0100 continuously; out_data follows in2; tenures restart every 4 beats.
REQ-031 Owner 1 mid-burst after 2 beats, out_ready=0 for 5 cycles, req[3] asserted -> gnt stays 4'b0010, bcnt stays 2; after out_ready returns, 2 more beats then gnt=4'b1000.
REQ-032 Owner 0 drops req after 1 beat while req[2]=1 -> next edge gnt=4'b0100, out_id=2, ptr=0.
REQ-033 Reset asserted during owner 3's tenure -> next cycle gnt=0, out_valid=0, out_id=0; with req=4'b1001 afterwards, requester 0 is granted first.
REQ-034 MAX_BURST=1, req=4'b0101, out_ready=1 -> grants alternate 0,2,0,2 with one beat each.
